// File: rtl/tdc_histogram_if.sv
// tdc_histogram_if: sample stream, run control/status and bin read port of the histogram.
interface tdc_histogram_if #(
  parameter int CODE_W = 8,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic              rd_en;
  logic [CODE_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  modport master (output start, code_valid, code, rd_en, rd_addr,
                  input  busy, done, overflow, rd_data, rd_valid);
  modport slave  (input  start, code_valid, code, rd_en, rd_addr,
                  output busy, done, overflow, rd_data, rd_valid);
endinterface

// File: rtl/tdc_histogram.sv
// tdc_histogram: code-density histogram with a 2-stage RMW pipeline over an inferred RAM.
module tdc_histogram #(
  parameter int CODE_W   = 8,
  parameter int CNT_W    = 32,
  parameter int NSAMPLES = 65536
) (
  input logic            clk,
  input logic            rst_n,
  tdc_histogram_if.slave bus
);
  localparam int BINS = 1 << CODE_W;
  typedef enum logic [2:0] {IDLE, CLEAR, ACQ, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] clr_q, clr_d;
  logic [24:0]       smp_q, smp_d;
  logic              drn_q, drn_d;
  logic              ovf_q, ovf_d;
  logic              s1_vld_q, s1_vld_d;
  logic [CODE_W-1:0] s1_addr_q, s1_addr_d;
  logic              w_vld_q;
  logic [CODE_W-1:0] w_addr_q;
  logic [CNT_W-1:0]  w_data_q;
  logic              rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  mem_q [BINS];
  logic [CNT_W-1:0]  mem_rd_q;
  logic              we, sat, accept;
  logic [CODE_W-1:0] waddr, raddr;
  logic [CNT_W-1:0]  wdata, cur, inc;
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    smp_d   = smp_q;
    drn_d   = drn_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = CLEAR;
        clr_d   = '0;
        smp_d   = '0;
        ovf_d   = 1'b0;
      end
      CLEAR: begin
        clr_d   = clr_q + CODE_W'(1);
        state_d = &clr_q ? ACQ : CLEAR;
      end
      ACQ: if (bus.code_valid) begin
        accept = 1'b1;
        smp_d  = smp_q + 25'd1;
        if (smp_d == 25'(NSAMPLES)) begin
          state_d = DRAIN;
          drn_d   = 1'b0;
        end
      end
      DRAIN: begin
        drn_d   = 1'b1;
        state_d = drn_q ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    // The previous write landed at the same edge as this sample's RAM read, so the RAM copy is stale.
    cur = (w_vld_q && w_addr_q == s1_addr_q) ? w_data_q : mem_rd_q;
    sat = &cur;
    inc = sat ? cur : cur + CNT_W'(1);
    if (s1_vld_q && sat) ovf_d = 1'b1;
    we        = (state_q == CLEAR) || s1_vld_q;
    waddr     = (state_q == CLEAR) ? clr_q : s1_addr_q;
    wdata     = (state_q == CLEAR) ? '0 : inc;
    raddr     = (state_q == ACQ) ? bus.code : bus.rd_addr;
    s1_vld_d  = accept;
    s1_addr_d = bus.code;
    rd_vld_d  = bus.rd_en && !bus.busy;
    hold_d    = rd_vld_q ? mem_rd_q : hold_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_q     <= '0;
      smp_q     <= '0;
      drn_q     <= 1'b0;
      ovf_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      w_vld_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      rd_vld_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      smp_q     <= smp_d;
      drn_q     <= drn_d;
      ovf_q     <= ovf_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      w_vld_q   <= s1_vld_q;
      w_addr_q  <= s1_addr_q;
      w_data_q  <= inc;
      rd_vld_q  <= rd_vld_d;
      hold_q    <= hold_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    mem_rd_q <= mem_q[raddr];
  end
  assign bus.busy     = (state_q == CLEAR) || (state_q == ACQ) || (state_q == DRAIN);
  assign bus.done     = state_q == DONE;
  assign bus.overflow = ovf_q;
  assign bus.rd_valid = rd_vld_q;
  assign bus.rd_data  = rd_vld_q ? mem_rd_q : hold_q;
endmodule
